// File: rtl/decode_regfile_sb.sv
// decode_regfile_sb: 32x32 register file with WB-to-decode bypass and a per-register in-flight write scoreboard
module decode_regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int CNT_W    = 2
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [4:0]      i_id_rs1_addr,
  input  logic [4:0]      i_id_rs2_addr,
  input  logic            i_id_rs1_used,
  input  logic            i_id_rs2_used,
  input  logic [4:0]      i_id_rd_addr,
  input  logic            i_id_rd_wren,
  input  logic            i_id_issue,
  input  logic            i_ex_squash,
  input  logic [4:0]      i_ex_squash_rd,
  input  logic [4:0]      i_wb_rd_addr,
  input  logic            i_wb_rd_wren,
  input  logic [XLEN-1:0] i_wb_data_wb,
  output logic [XLEN-1:0] o_id_rs1_data,
  output logic [XLEN-1:0] o_id_rs2_data,
  output logic            o_id_stall,
  output logic            o_sb_error
);
  localparam logic [CNT_W-1:0]        CNT_MAX = '1;
  localparam logic signed [CNT_W+1:0] S_MAX   = (CNT_W+2)'(2**CNT_W-1);
  logic [XLEN-1:0]                   r_regs [NUM_REGS];
  logic [NUM_REGS-1:0][CNT_W-1:0]    r_cnt;
  logic                              r_err;
  logic [NUM_REGS-1:0][CNT_W-1:0]    w_nxt;
  logic [NUM_REGS-1:0]               w_pend;
  logic [NUM_REGS-1:0]               w_err;
  logic                              w_issue;
  assign w_issue = i_id_issue && !o_id_stall;
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_sb
    logic                     w_inc, w_dwb, w_dsq;
    logic signed [CNT_W+1:0]  w_pre, w_sum;
    assign w_inc = w_issue && i_id_rd_wren && i_id_rd_addr == 5'(g);
    assign w_dwb = i_wb_rd_wren && i_wb_rd_addr == 5'(g);
    assign w_dsq = i_ex_squash && i_ex_squash_rd == 5'(g);
    // pending uses the pre-issue count so an instruction never stalls on its own rd
    assign w_pre = {2'b00, r_cnt[g]} - (CNT_W+2)'(w_dwb) - (CNT_W+2)'(w_dsq);
    assign w_sum = w_pre + (CNT_W+2)'(w_inc);
    assign w_pend[g] = (g != 0) && (w_pre > 0);
    assign w_err[g] = (g != 0) && (w_sum < 0 || w_sum > S_MAX);
    assign w_nxt[g] = (g == 0) ? '0 : (w_sum < 0) ? '0 : (w_sum > S_MAX) ? CNT_MAX : w_sum[CNT_W-1:0];
  end
  always_comb begin
    o_id_rs1_data = (i_id_rs1_addr == 5'd0) ? '0 :
                    (i_wb_rd_wren && i_wb_rd_addr == i_id_rs1_addr) ? i_wb_data_wb : r_regs[i_id_rs1_addr];
    o_id_rs2_data = (i_id_rs2_addr == 5'd0) ? '0 :
                    (i_wb_rd_wren && i_wb_rd_addr == i_id_rs2_addr) ? i_wb_data_wb : r_regs[i_id_rs2_addr];
    o_id_stall    = (i_id_rs1_used && w_pend[i_id_rs1_addr]) || (i_id_rs2_used && w_pend[i_id_rs2_addr]);
    o_sb_error    = r_err;
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_wb_rd_wren && i_wb_rd_addr != 5'd0) r_regs[i_wb_rd_addr] <= i_wb_data_wb;
      r_cnt <= w_nxt;
      r_err <= r_err | (|w_err);
    end
  end
endmodule

// File: tb/tb_decode_regfile_sb.sv
// tb_decode_regfile_sb: directed spec scenarios then randomized traffic against a counting reference model
module tb_decode_regfile_sb;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs1, rs2, rd, sq_rd, wb_addr;
  logic        rs1_used, rs2_used, rd_wren, issue, squash, wb_wren;
  logic [31:0] wb_data, rs1_data, rs2_data;
  logic        stall, sb_err;
  int          total = 0, bad = 0;
  logic [31:0] m_reg [32];
  int          m_cnt [32];
  bit          m_err;
  bit          m_stall;
  always #5 clk = ~clk;
  decode_regfile_sb dut (
    .i_clk(clk), .i_reset(rst),
    .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2), .i_id_rs1_used(rs1_used), .i_id_rs2_used(rs2_used),
    .i_id_rd_addr(rd), .i_id_rd_wren(rd_wren), .i_id_issue(issue),
    .i_ex_squash(squash), .i_ex_squash_rd(sq_rd),
    .i_wb_rd_addr(wb_addr), .i_wb_rd_wren(wb_wren), .i_wb_data_wb(wb_data),
    .o_id_rs1_data(rs1_data), .o_id_rs2_data(rs2_data), .o_id_stall(stall), .o_sb_error(sb_err)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (wb_wren && wb_addr == a) return wb_data;
    return m_reg[a];
  endfunction
  // a register is busy if writes remain outstanding after this cycle's retirements
  function automatic bit m_busy(input logic [4:0] a);
    int left;
    left = m_cnt[a] - ((wb_wren && wb_addr == a) ? 1 : 0) - ((squash && sq_rd == a) ? 1 : 0);
    return a != 0 && left > 0;
  endfunction
  task automatic idle();
    rst = 0; rs1 = 0; rs2 = 0; rs1_used = 0; rs2_used = 0; rd = 0; rd_wren = 0; issue = 0;
    squash = 0; sq_rd = 0; wb_addr = 0; wb_wren = 0; wb_data = 0;
  endtask
  task automatic eval();
    #2;
    m_stall = (rs1_used && m_busy(rs1)) || (rs2_used && m_busy(rs2));
    chk("rs1_data", rs1_data, m_read(rs1));
    chk("rs2_data", rs2_data, m_read(rs2));
    chk("stall", {31'd0, stall}, {31'd0, m_stall});
    chk("sb_error", {31'd0, sb_err}, {31'd0, m_err});
  endtask
  task automatic tick();
    int n;
    if (rst) begin
      for (int r = 0; r < 32; r++) begin m_reg[r] = 0; m_cnt[r] = 0; end
      m_err = 0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        n = m_cnt[r];
        if (issue && !m_stall && rd_wren && rd == r) n++;
        if (wb_wren && wb_addr == r) n--;
        if (squash && sq_rd == r) n--;
        if (n > 3) begin n = 3; m_err = 1; end
        if (n < 0) begin n = 0; m_err = 1; end
        m_cnt[r] = n;
      end
      if (wb_wren && wb_addr != 0) m_reg[wb_addr] = wb_data;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic cyc();
    eval();
    tick();
  endtask
  task automatic do_reset();
    idle(); rst = 1; cyc(); rst = 0;
  endtask
  initial begin
    for (int r = 0; r < 32; r++) begin m_reg[r] = 0; m_cnt[r] = 0; end
    m_err = 0; m_stall = 0;
    idle();
    @(posedge clk); #1;
    do_reset();
    // registers clear, x0 ignores writes
    for (int i = 1; i < 32; i++) begin
      idle(); rs1 = 5'(i); rs2 = 5'(32 - i); eval(); chk("reset_zero", rs1_data, 32'd0); tick();
    end
    idle(); wb_wren = 1; wb_addr = 0; wb_data = 32'hFFFF_FFFF; cyc();
    idle(); rs1 = 0; eval(); chk("x0_zero", rs1_data, 32'd0); tick();
    // same-cycle bypass
    idle(); wb_wren = 1; wb_addr = 5; wb_data = 32'hDEAD_BEEF; rs1 = 5; rs1_used = 1;
    eval(); chk("bypass", rs1_data, 32'hDEAD_BEEF); chk("bypass_nostall", {31'd0, stall}, 32'd0); tick();
    idle(); rs2 = 5; eval(); chk("x5_stored", rs2_data, 32'hDEAD_BEEF); tick();
    do_reset();
    // RAW stall until writeback
    idle(); issue = 1; rd = 7; rd_wren = 1; cyc();
    idle(); rs2 = 7; rs2_used = 1; issue = 1;
    eval(); chk("raw_stall1", {31'd0, stall}, 32'd1); tick();
    eval(); chk("raw_stall2", {31'd0, stall}, 32'd1); tick();
    wb_wren = 1; wb_addr = 7; wb_data = 32'h1234_5678;
    eval(); chk("raw_release", {31'd0, stall}, 32'd0); chk("raw_bypass", rs2_data, 32'h1234_5678); tick();
    // two writes in flight
    idle(); issue = 1; rd = 3; rd_wren = 1; cyc(); cyc();
    idle(); rs1 = 3; rs1_used = 1; wb_wren = 1; wb_addr = 3; wb_data = 32'h11;
    eval(); chk("two_wb1_stall", {31'd0, stall}, 32'd1); tick();
    wb_data = 32'h22;
    eval(); chk("two_wb2_stall", {31'd0, stall}, 32'd0); chk("two_wb2_data", rs1_data, 32'h22); tick();
    // squash retires the in-flight write
    idle(); issue = 1; rd = 9; rd_wren = 1; cyc();
    idle(); squash = 1; sq_rd = 9; rs1 = 9; rs1_used = 1;
    eval(); chk("squash_nostall", {31'd0, stall}, 32'd0); tick();
    idle(); rs1 = 9; rs1_used = 1; eval(); chk("squash_cnt0", {31'd0, stall}, 32'd0); tick();
    idle(); wb_wren = 1; wb_addr = 9; wb_data = 32'h99; cyc();
    idle(); eval(); chk("underflow_err", {31'd0, sb_err}, 32'd1); tick();
    // overflow
    do_reset();
    idle(); issue = 1; rd = 4; rd_wren = 1; cyc(); cyc(); cyc();
    eval(); chk("pre_ovf_err", {31'd0, sb_err}, 32'd0); tick();
    idle(); eval(); chk("overflow_err", {31'd0, sb_err}, 32'd1); tick();
    idle(); wb_wren = 1; wb_addr = 4; cyc(); cyc();
    idle(); rs1 = 4; rs1_used = 1; eval(); chk("ovf_hold3", {31'd0, stall}, 32'd1); tick();
    idle(); wb_wren = 1; wb_addr = 4; rs1 = 4; rs1_used = 1;
    eval(); chk("ovf_last_wb", {31'd0, stall}, 32'd0); tick();
    idle(); issue = 1; rd = 4; rd_wren = 1; cyc();
    do_reset();
    idle(); rs1 = 4; rs1_used = 1;
    eval(); chk("rst_err", {31'd0, sb_err}, 32'd0); chk("rst_stall", {31'd0, stall}, 32'd0); tick();
    // random traffic concentrated on a few registers to provoke hazards
    for (int k = 0; k < 600; k++) begin
      idle();
      rst      = ($urandom_range(0, 49) == 0);
      rs1      = 5'($urandom_range(0, 7));
      rs2      = 5'($urandom_range(0, 7));
      rs1_used = 1'($urandom);
      rs2_used = 1'($urandom);
      rd       = 5'($urandom_range(0, 7));
      rd_wren  = ($urandom_range(0, 3) != 0);
      issue    = 1'($urandom);
      squash   = ($urandom_range(0, 9) == 0);
      sq_rd    = 5'($urandom_range(0, 7));
      wb_wren  = 1'($urandom);
      wb_addr  = 5'($urandom_range(0, 7));
      wb_data  = $urandom;
      cyc();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
